// File: rtl/stream_arbiter_bb_pkg.sv
// Shared defaults, error codes and state encoding for the stream arbiter.
package stream_arbiter_bb_pkg;

  localparam int unsigned DEF_N_SRC         = 4;
  localparam int unsigned DEF_LOG_N_SRC     = 2;
  localparam int unsigned DEF_WDTH          = 32;
  localparam int unsigned DEF_MAX_BURST     = 4;
  localparam int unsigned DEF_LOG_MAX_BURST = 3;

  localparam logic [31:0] DEF_WRITE_ERR_CODE = 32'hDEAD0001;
  localparam logic [31:0] DEF_READ_ERR_CODE  = 32'hDEAD0002;

  typedef enum logic {
    ARB    = 1'b0,
    SETTLE = 1'b1
  } state_e;

endpackage

// File: rtl/stream_arbiter_bb_if.sv
// Buffer-bank and output-stream signals seen by the arbiter.
interface stream_arbiter_bb_if
  import stream_arbiter_bb_pkg::*;
#(
  parameter int unsigned N_SRC     = DEF_N_SRC,
  parameter int unsigned WDTH      = DEF_WDTH,
  parameter int unsigned LOG_N_SRC = DEF_LOG_N_SRC
);

  logic [N_SRC-1:0]      buf_full;
  logic [N_SRC*WDTH-1:0] buf_data;
  logic [N_SRC-1:0]      buf_write_error;
  logic [N_SRC-1:0]      buf_read_error;
  logic [N_SRC-1:0]      buf_delete;
  logic [WDTH-1:0]       out_data;
  logic                  out_nd;
  logic [LOG_N_SRC-1:0]  out_src;
  logic                  err_sticky;

  // Arbiter side
  modport master (
    input  buf_full, buf_data, buf_write_error, buf_read_error,
    output buf_delete, out_data, out_nd, out_src, err_sticky
  );

  // Buffer bank / consumer side
  modport slave (
    output buf_full, buf_data, buf_write_error, buf_read_error,
    input  buf_delete, out_data, out_nd, out_src, err_sticky
  );

endinterface

// File: rtl/stream_arbiter_bb_rr_find_next.sv
// Rotating priority encoder: first set request at or after start, wrapping modulo N.
module rr_find_next #(
  parameter int unsigned N    = 4,
  parameter int unsigned LOGN = 2
) (
  input  logic [N-1:0]    req,
  input  logic [LOGN-1:0] start,
  output logic            found_c,
  output logic [LOGN-1:0] idx_c
);

  function automatic logic [LOGN-1:0] wrap_idx(input int unsigned s, input int unsigned k);
    int unsigned p;
    p = s + k;
    if (p >= N) p = p - N;
    return LOGN'(p);
  endfunction

  always_comb begin
    found_c = 1'b0;
    idx_c   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!found_c && req[wrap_idx(32'(start), k)]) begin
        found_c = 1'b1;
        idx_c   = wrap_idx(32'(start), k);
      end
    end
  end

endmodule

// File: rtl/stream_arbiter_bb.sv
// Round-robin reader sharing one output stream among N_SRC buffers, with error words injected in-band.
module stream_arbiter_bb
  import stream_arbiter_bb_pkg::*;
#(
  parameter int unsigned N_SRC          = DEF_N_SRC,
  parameter int unsigned LOG_N_SRC      = DEF_LOG_N_SRC,
  parameter int unsigned WDTH           = DEF_WDTH,
  parameter int unsigned MAX_BURST      = DEF_MAX_BURST,
  parameter int unsigned LOG_MAX_BURST  = DEF_LOG_MAX_BURST,
  parameter logic [WDTH-1:0] WRITE_ERR_CODE = WDTH'(DEF_WRITE_ERR_CODE),
  parameter logic [WDTH-1:0] READ_ERR_CODE  = WDTH'(DEF_READ_ERR_CODE)
) (
  input  logic                clk,
  input  logic                rst_n,
  stream_arbiter_bb_if.master bus
);

  state_e                   state, state_d;
  logic [LOG_N_SRC-1:0]     cur, cur_d;
  logic [LOG_MAX_BURST-1:0] cnt, cnt_d;

  logic [N_SRC-1:0]     delete_d;
  logic [WDTH-1:0]      data_d;
  logic                 nd_d;
  logic [LOG_N_SRC-1:0] src_d;
  logic                 sticky_d;

  logic [LOG_N_SRC-1:0] rr_start, rr_idx, err_idx, rd_sel;
  logic                 rr_found, err_found, any_wr, cont, do_read;
  logic [N_SRC-1:0]     err_req;
  logic [WDTH-1:0]      word [N_SRC];

  for (genvar g = 0; g < N_SRC; g++) begin : g_word
    assign word[g] = bus.buf_data[g*WDTH +: WDTH];
  end

  // Write errors outrank read errors; lowest index wins within a type
  assign any_wr  = |bus.buf_write_error;
  assign err_req = any_wr ? bus.buf_write_error : bus.buf_read_error;

  // Search begins just after the current source so it is considered last
  assign rr_start = (32'(cur) + 1 >= N_SRC) ? '0 : cur + LOG_N_SRC'(1);
  assign cont     = (cnt != '0) && bus.buf_full[cur] && (32'(cnt) < MAX_BURST);
  assign do_read  = (state == ARB) && !err_found && (cont || rr_found);
  assign rd_sel   = cont ? cur : rr_idx;

  rr_find_next #(.N(N_SRC), .LOGN(LOG_N_SRC)) u_rr_sel (
    .req     (bus.buf_full),
    .start   (rr_start),
    .found_c (rr_found),
    .idx_c   (rr_idx)
  );

  rr_find_next #(.N(N_SRC), .LOGN(LOG_N_SRC)) u_err_sel (
    .req     (err_req),
    .start   (LOG_N_SRC'(0)),
    .found_c (err_found),
    .idx_c   (err_idx)
  );

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state          <= ARB;
      cur            <= LOG_N_SRC'(N_SRC - 1);
      cnt            <= '0;
      bus.buf_delete <= '0;
      bus.out_data   <= '0;
      bus.out_nd     <= 1'b0;
      bus.out_src    <= '0;
      bus.err_sticky <= 1'b0;
    end else begin
      state          <= state_d;
      cur            <= cur_d;
      cnt            <= cnt_d;
      bus.buf_delete <= delete_d;
      bus.out_data   <= data_d;
      bus.out_nd     <= nd_d;
      bus.out_src    <= src_d;
      bus.err_sticky <= sticky_d;
    end
  end

  // Next state: an error cycle leaves cur/cnt untouched
  always_comb begin
    state_d = state;
    cur_d   = cur;
    cnt_d   = cnt;
    if (err_found) begin
      state_d = ARB;
    end else if (state == SETTLE) begin
      state_d = ARB;
    end else if (do_read) begin
      state_d = SETTLE;
      cur_d   = rd_sel;
      cnt_d   = cont ? cnt + LOG_MAX_BURST'(1) : LOG_MAX_BURST'(1);
    end else begin
      cnt_d   = '0;
    end
  end

  // Outputs: data/src hold when no word is emitted
  always_comb begin
    delete_d = '0;
    data_d   = bus.out_data;
    nd_d     = 1'b0;
    src_d    = bus.out_src;
    sticky_d = bus.err_sticky;
    if (err_found) begin
      nd_d     = 1'b1;
      data_d   = any_wr ? WRITE_ERR_CODE : READ_ERR_CODE;
      src_d    = err_idx;
      sticky_d = 1'b1;
    end else if (do_read) begin
      delete_d = N_SRC'(1) << rd_sel;
      nd_d     = 1'b1;
      data_d   = word[rd_sel];
      src_d    = rd_sel;
    end
  end

endmodule

// File: tb/tb_stream_arbiter_bb.sv
// Randomized scoreboard bench for stream_arbiter_bb with a behavioural buffer bank and reference model.
module tb_stream_arbiter_bb;

  localparam int unsigned N         = 4;
  localparam int unsigned MAXB      = 4;
  localparam logic [31:0] WR_CODE   = 32'hDEAD0001;
  localparam logic [31:0] RD_CODE   = 32'hDEAD0002;

  logic clk;
  logic rst_n;
  int   cyc = 0;

  stream_arbiter_bb_if #(.N_SRC(4), .WDTH(32), .LOG_N_SRC(2)) bus ();

  stream_arbiter_bb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          cyc;
    logic [31:0] data;
    int unsigned src;
    logic [3:0]  del;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   mon_en   = 1'b0;

  // Buffer bank: one circular store per source
  bit [31:0]   mem [4][256];
  int unsigned head [4];
  int unsigned tail [4];
  bit [3:0]    push_en   = '0;
  bit          keep_full = 1'b0;
  int unsigned push_pct  = 0;
  int unsigned err_pct   = 0;

  logic [3:0]  drv_full, drv_wr, drv_rd;
  logic [31:0] front [4];
  logic        drv_rst;

  // Reference model state
  bit          m_settle;
  int unsigned m_last;
  int unsigned m_run;
  bit          m_sticky;
  logic [31:0] m_hold_data;
  int unsigned m_hold_src;
  bit          exp_sticky    = 1'b0;
  logic [31:0] exp_hold_data = '0;
  int unsigned exp_hold_src  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, required %h", name, cyc, act, exp);
    end
  endtask

  task automatic buf_push(input int i, input logic [31:0] v);
    mem[i][tail[i] % 256] = v;
    tail[i]++;
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < 4; i++) head[i] = tail[i];
  endtask

  function automatic int unsigned lowest(input logic [3:0] v);
    for (int k = 0; k < 4; k++) if (v[k]) return k;
    return 0;
  endfunction

  task automatic emit(input logic [31:0] d, input int unsigned s, input logic [3:0] del);
    exp_t e;
    e.cyc = cyc + 1; e.data = d; e.src = s; e.del = del;
    exp_q.push_back(e);
    m_hold_data = d;
    m_hold_src  = s;
  endtask

  // Behaviour for the next clock edge, from the inputs just driven
  task automatic model_step();
    int pick;
    if (!drv_rst) begin
      m_settle = 0; m_last = N - 1; m_run = 0; m_sticky = 0;
      m_hold_data = '0; m_hold_src = 0;
    end else if (drv_wr != 0) begin
      emit(WR_CODE, lowest(drv_wr), 4'b0000);
      m_sticky = 1; m_settle = 0;
    end else if (drv_rd != 0) begin
      emit(RD_CODE, lowest(drv_rd), 4'b0000);
      m_sticky = 1; m_settle = 0;
    end else if (m_settle) begin
      m_settle = 0;
    end else begin
      pick = -1;
      if (m_run > 0 && m_run < MAXB && drv_full[m_last]) begin
        pick = int'(m_last);
        m_run++;
      end else begin
        for (int k = 1; k <= int'(N); k++) begin
          int c;
          c = (int'(m_last) + k) % int'(N);
          if (pick < 0 && drv_full[c]) pick = c;
        end
        m_run = (pick >= 0) ? 1 : 0;
      end
      if (pick >= 0) begin
        emit(front[pick], pick, 4'(1 << pick));
        m_last   = pick;
        m_settle = 1;
      end
    end
  endtask

  // One clock of environment: buffers react to deletes, then new inputs and the model step
  task automatic step(input logic rst_v, input logic [3:0] wr_f, input logic [3:0] rd_f);
    @(posedge clk);
    #2;
    exp_sticky    = m_sticky;
    exp_hold_data = m_hold_data;
    exp_hold_src  = m_hold_src;
    mon_en        = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (bus.buf_delete[i] && tail[i] != head[i]) head[i]++;
      if (push_en[i] && (tail[i] - head[i]) < 8) begin
        if (keep_full ? ((tail[i] - head[i]) < 3) : ($urandom_range(99) < push_pct))
          buf_push(i, $urandom);
      end
      drv_full[i] = (tail[i] != head[i]);
      front[i]    = mem[i][head[i] % 256];
    end
    drv_wr = wr_f;
    drv_rd = rd_f;
    for (int i = 0; i < 4; i++) begin
      if ($urandom_range(99) < err_pct) drv_wr[i] = 1'b1;
      if ($urandom_range(99) < err_pct) drv_rd[i] = 1'b1;
    end
    drv_rst             = rst_v;
    bus.buf_full        = drv_full;
    bus.buf_data        = {front[3], front[2], front[1], front[0]};
    bus.buf_write_error = drv_wr;
    bus.buf_read_error  = drv_rd;
    rst_n               = rst_v;
    model_step();
  endtask

  // Monitor: compare every DUT output cycle against the scoreboard
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        check("err_sticky", 32'(bus.err_sticky), 32'(exp_sticky));
        if (bus.out_nd) begin
          if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
            n_checks++; n_fail++;
            $display("FAIL unexpected_word at cycle %0d: got src %0d data %h, required no word",
                     cyc, bus.out_src, bus.out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_data", bus.out_data, e.data);
            check("out_src", 32'(bus.out_src), e.src);
            check("buf_delete", 32'(bus.buf_delete), 32'(e.del));
          end
        end else begin
          if (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
            e = exp_q.pop_front();
            n_checks++; n_fail++;
            $display("FAIL missing_word at cycle %0d: got out_nd 0, required src %0d data %h",
                     cyc, e.src, e.data);
          end
          check("idle_delete", 32'(bus.buf_delete), 32'h0);
          check("hold_data", bus.out_data, exp_hold_data);
          check("hold_src", 32'(bus.out_src), exp_hold_src);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    drv_rst = 1'b0;
    drv_full = '0; drv_wr = '0; drv_rd = '0;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0; tail[i] = 0; front[i] = '0;
    end
    bus.buf_full = '0; bus.buf_data = '0;
    bus.buf_write_error = '0; bus.buf_read_error = '0;
    m_settle = 0; m_last = N - 1; m_run = 0; m_sticky = 0;
    m_hold_data = '0; m_hold_src = 0;

    repeat (2) step(1'b0, 4'b0, 4'b0);

    // Lone source 2 with a stepping data pattern
    for (int v = 0; v < 10; v++) buf_push(2, 32'hA0 + v);
    repeat (26) step(1'b1, 4'b0, 4'b0);

    // Source 1 empties after two words while source 3 waits
    step(1'b0, 4'b0, 4'b0);
    clear_bufs();
    buf_push(1, 32'h1111_0001); buf_push(1, 32'h1111_0002);
    for (int v = 0; v < 6; v++) buf_push(3, 32'h3333_0000 + v);
    repeat (20) step(1'b1, 4'b0, 4'b0);

    // All sources kept full: bursts of MAX_BURST in rotation
    push_en = 4'hF; keep_full = 1'b1;
    repeat (40) step(1'b1, 4'b0, 4'b0);

    // Simultaneous write error on 3 and read error on 1 with source 0 waiting
    push_en = '0; keep_full = 1'b0;
    clear_bufs();
    repeat (3) step(1'b1, 4'b0, 4'b0);
    buf_push(0, 32'h0000_C0DE);
    step(1'b1, 4'b1000, 4'b0010);
    repeat (4) step(1'b1, 4'b0, 4'b0);

    // Reset in the middle of full-bank traffic, then restart
    push_en = 4'hF; keep_full = 1'b1;
    repeat (7) step(1'b1, 4'b0, 4'b0);
    step(1'b0, 4'b0, 4'b0);
    repeat (12) step(1'b1, 4'b0, 4'b0);

    // Random traffic with sparse error strobes
    keep_full = 1'b0; push_pct = 30; err_pct = 2;
    repeat (400) step(1'b1, 4'b0, 4'b0);

    // Drain
    push_en = '0; err_pct = 0;
    repeat (100) step(1'b1, 4'b0, 4'b0);

    @(negedge clk);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/stream_arbiter_bb.md
Name: stream_arbiter_BB

Overview:
Round-robin read controller sharing one output stream among N_SRC buffer_BB instances.
- Watches each buffer's read_full/read_data and pulses that buffer's read_delete when a word is taken.
- Forwards the word as out_data/out_nd, tagged with its source index.
- Turns buffer write/read error strobes into error-code words on the same stream.
- Sits between a bank of per-channel buffers and a single downstream consumer or QA harness.

Parameters:
N_SRC, 4, number of buffer sources.
LOG_N_SRC, 2, width of source index (clog2 of N_SRC).
WDTH, 32, data width.
MAX_BURST, 4, max consecutive words granted to one source before rotation (>=1).
LOG_MAX_BURST, 3, width of burst counter (holds 0..MAX_BURST).
WRITE_ERR_CODE, 32'hDEAD0001, out_data emitted for a buffer write error.
READ_ERR_CODE, 32'hDEAD0002, out_data emitted for a buffer read error.

Ports:
clk  input  1  clock, all logic on rising edge.
rst_n  input  1  synchronous, active-low reset.
buf_full  input  N_SRC  per-source read_full (word available).
buf_data  input  N_SRC*WDTH  per-source read_data; source i occupies bits [i*WDTH +: WDTH].
buf_write_error  input  N_SRC  per-source write_error strobe.
buf_read_error  input  N_SRC  per-source read_error strobe.
buf_delete  output  N_SRC  per-source read_delete; registered, one-hot or zero.
out_data  output  WDTH  forwarded word or error code; registered.
out_nd  output  1  out_data valid this cycle; registered.
out_src  output  LOG_N_SRC  source index of the current out_data.
err_sticky  output  1  set on any error word; cleared only by reset.

Behaviour:
- Reset (rst_n low at clk edge): buf_delete=0, out_data=0, out_nd=0, out_src=0, err_sticky=0, state=ARB, cur=N_SRC-1, cnt=0. A reset mid-burst or mid-SETTLE aborts with no further deletes.
- Output latency: one cycle. out_data/out_nd/out_src/buf_delete all update on the same edge and sample inputs from the previous cycle.
- Error check, evaluated every cycle before anything else:
  - Any buf_write_error beats any buf_read_error.
  - Within the same error type, the lowest index wins.
  - Result: out_nd=1, out_data=code, out_src=index, err_sticky<=1, buf_delete=0.
  - Errors on other sources in the same cycle are dropped; only one error word is emitted.
- State ARB, no error:
  - Continue burst: if cnt>0 and buf_full[cur] and cnt<MAX_BURST, read cur and cnt++.
  - Otherwise search rotationally from cur+1 mod N_SRC (cur is last in the order) for the first full source i, read it, set cur=i, cnt=1.
  - If no source is full: cnt=0, out_nd=0, buf_delete=0, stay in ARB.
- Read action: buf_delete[i]=1 for one cycle, out_nd=1, out_data=buf_data[i], out_src=i, next state=SETTLE.
- State SETTLE: buf_delete=0. out_nd=0 unless an error word is emitted. Next state=ARB. This gives each buffer one cycle to update full/data after a delete.
- Error in ARB: no read that cycle, stay in ARB, cnt unchanged.
- Error in SETTLE: error word emitted, go to ARB.
- Throughput: at most one word every 2 cycles.
- Fairness: a source gets at most MAX_BURST consecutive reads while others are waiting. If it is the only full source, it is re-granted with cnt=1.
- out_data/out_src hold their last value when out_nd=0.
- Widths: cnt saturates at MAX_BURST; index arithmetic is modulo N_SRC (N_SRC need not be a power of 2).

Decomposition:
- Shared include/package: error codes, state encodings (ARB=1'b0, SETTLE=1'b1), default widths.
- One sub-module, rr_find_next: combinational rotating priority encoder.
  - Inputs: request vector and start index.
  - Outputs: found flag and granted index.
  - Reused for the lowest-index error select with start=0.

Test Plan:
- Only buf_full[2]=1 with buf_data source 2 stepping 0xA0,0xA1,0xA2 after each delete -> buf_delete=4'b0100 every other cycle; out_nd pulses carry 0xA0,0xA1,0xA2 with out_src=2, each one cycle after the delete decision; cnt rolls 4 then re-grants src2.
- All four buf_full held high, MAX_BURST=4 -> out_src sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0...; never two deletes on consecutive cycles.
- src1 granted, drops full after 2 words while src3 full -> next ARB reads src3 with cnt=1; src1 is not re-read until src3's burst ends or src3 empties.
- buf_write_error[3] and buf_read_error[1] in the same cycle, src0 full -> out_data=WRITE_ERR_CODE, out_src=3, err_sticky=1, buf_delete=0; the src1 read error is dropped; src0 is read on the following ARB cycle.
- rst_n low for one cycle during SETTLE of a src2 burst -> next edge all outputs 0, err_sticky cleared; after release with all sources full, the first read is src0.
